reg_vga_irq: RTL and testbench

//  Second-generation VGA register block on the local bus: control, live blank status,

---
 rtl/reg_vga_irq.sv | 144 ++++++++++++++
 tb/tb_reg_vga_irq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_vga_irq.sv
// reg_vga_irq: VGA register block on the local bus.
//   Control register, live (synchronised) blank status, sticky blank-rise interrupts with
//   enables, optional frame counter and NUM_SCROLL double-buffered scroll registers whose
//   active copies load from the pending copies on each vblank rising edge.
// Optional feature macro: REG_VGA_FRAME_CNT_EN (frame counter present when defined;
//   otherwise word 3 reads 0 and writes to it are ignored).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sel, addr, we,      local-bus select, byte address (addr[5:2] decoded), byte enables,
//   wdata, rdata        write data, combinational read data (0 when !sel or unmapped)
//   vga_en              VGA enable (CTRL[0])
//   scroll              active scroll values, entry i at [16i+15:16i]
//   irq                 level interrupt, |(INT_STAT & IE)
//   vblank, hblank      asynchronous blank levels from the timing generator
module reg_vga_irq #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_SCROLL  = 2,
   parameter int unsigned FCNT_W      = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       sel,
   input  logic [XLEN-1:0]            addr,
   input  logic [3:0]                 we,
   input  logic [XLEN-1:0]            wdata,
   output logic [31:0]                rdata,
   output logic                       vga_en,
   output logic [16*NUM_SCROLL-1:0]   scroll,
   output logic                       irq,
   input  logic                       vblank,
   input  logic                       hblank
);

   logic [3:0] word;
   assign word = addr[5:2];

   // Bit 0 tracks vblank, bit 1 tracks hblank throughout.
   logic [SYNC_STAGES-1:0][1:0] sync_q;
   logic [1:0]                  prev_q;
   logic [1:0]                  blank_s;
   logic [1:0]                  rise;
   // Fills with ones after reset; edges are only reported once both the sync chain and the
   // history flop hold post-reset samples, so a level already high at release is no edge.
   logic [SYNC_STAGES:0]        arm_q;

   assign blank_s = sync_q[SYNC_STAGES-1];
   assign rise    = blank_s & ~prev_q & {2{arm_q[SYNC_STAGES]}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= '0;
         arm_q  <= '0;
      end else begin
         sync_q[0] <= {hblank, vblank};
         for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
         prev_q <= blank_s;
         arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   logic [2:0]                        ctrl_q, ctrl_d;
   logic [1:0]                        int_stat_q, int_stat_d;
   logic [NUM_SCROLL-1:0][15:0]       pend_q, pend_d;
   logic [NUM_SCROLL-1:0][15:0]       act_q, act_d;

   always_comb begin
      ctrl_d     = ctrl_q;
      int_stat_d = int_stat_q;
      pend_d     = pend_q;
      if (sel && we[0] && word == 4'd0) ctrl_d = wdata[2:0];
      if (sel && we[0] && word == 4'd2) int_stat_d = int_stat_q & ~wdata[1:0];
      // New edges are OR-ed in after the clear so a coincident rise wins.
      int_stat_d = int_stat_d | rise;
      for (int i = 0; i < int'(NUM_SCROLL); i++) begin
         if (sel && word == 4'(4 + i)) begin
            if (we[0]) pend_d[i][7:0]  = wdata[7:0];
            if (we[1]) pend_d[i][15:8] = wdata[15:8];
         end
      end
      // Transfer from pend_d so a write landing on the rise edge is taken immediately.
      act_d = rise[0] ? pend_d : act_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q     <= '0;
         int_stat_q <= '0;
         pend_q     <= '0;
         act_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         int_stat_q <= int_stat_d;
         pend_q     <= pend_d;
         act_q      <= act_d;
      end
   end

   logic [31:0] frame_rd;

`ifdef REG_VGA_FRAME_CNT_EN
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   always_comb begin
      fcnt_d = (sel && (we != 4'b0000) && word == 4'd3) ? '0 : fcnt_q;
      fcnt_d = fcnt_d + FCNT_W'(rise[0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fcnt_q <= '0;
      else        fcnt_q <= fcnt_d;
   end

   assign frame_rd = 32'(fcnt_q);
`else
   assign frame_rd = '0;
`endif

   assign vga_en = ctrl_q[0];
   assign scroll = act_q;
   assign irq    = |(int_stat_q & ctrl_q[2:1]);

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (word)
            4'd0:    rdata = {29'b0, ctrl_q};
            4'd1:    rdata = {30'b0, blank_s};
            4'd2:    rdata = {30'b0, int_stat_q};
            4'd3:    rdata = frame_rd;
            default: begin
               for (int i = 0; i < int'(NUM_SCROLL); i++) begin
                  if (word == 4'(4 + i)) rdata = {16'b0, pend_q[i]};
               end
            end
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{addr[XLEN-1:6], addr[1:0], wdata[XLEN-1:16], we[3:2]};

endmodule

// File: tb/tb_reg_vga_irq.sv
// Scoreboard bench for reg_vga_irq: stimulus tasks push expected values, the monitor pops
// and compares on the falling edge whenever a check is requested.
module tb_reg_vga_irq;
   localparam int unsigned XLEN        = 32;
   localparam int unsigned NUM_SCROLL  = 2;
   localparam int unsigned FCNT_W      = 4;
   localparam int unsigned SYNC_STAGES = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     sel = 1'b0;
   logic [XLEN-1:0]          addr = '0;
   logic [3:0]               we = '0;
   logic [XLEN-1:0]          wdata = '0;
   logic [31:0]              rdata;
   logic                     vga_en;
   logic [16*NUM_SCROLL-1:0] scroll;
   logic                     irq;
   logic                     vblank = 1'b0;
   logic                     hblank = 1'b0;

   always #5 clk = ~clk;

   reg_vga_irq #(
      .XLEN(XLEN), .NUM_SCROLL(NUM_SCROLL), .FCNT_W(FCNT_W), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .we(we), .wdata(wdata),
      .rdata(rdata), .vga_en(vga_en), .scroll(scroll), .irq(irq),
      .vblank(vblank), .hblank(hblank)
   );

   // kind: 0 rdata, 1 irq, 2 vga_en, 3 scroll
   typedef struct {
      int          kind;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   logic        chk_req = 1'b0;
   logic        done_req = 1'b0;
   int          total = 0;
   int          bad = 0;
   exp_t        e;
   logic [31:0] act;

   always @(negedge clk) begin
      if (chk_req) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: check requested with no expectation");
         end else begin
            e = sb.pop_front();
            case (e.kind)
               0:       act = rdata;
               1:       act = {31'b0, irq};
               2:       act = {31'b0, vga_en};
               default: act = 32'(scroll);
            endcase
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s: got %h want %h", e.name, act, e.exp);
            end
         end
      end
      if (done_req) begin
         total++;
         if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
         end
      end
   end

   task automatic push(input int kind, input logic [31:0] exp, input string name);
      exp_t x;
      x.kind = kind;
      x.exp  = exp;
      x.name = name;
      sb.push_back(x);
   endtask

   task automatic wr(input int w, input logic [3:0] be, input logic [31:0] d);
      @(posedge clk); #1;
      sel = 1'b1; addr = 32'(w << 2); we = be; wdata = d;
      @(posedge clk); #1;
      sel = 1'b0; we = '0;
   endtask

   task automatic chk_rd(input int w, input logic [31:0] exp, input string name);
      @(posedge clk); #1;
      sel = 1'b1; we = '0; addr = 32'(w << 2);
      push(0, exp, name);
      chk_req = 1'b1;
      @(posedge clk); #1;
      chk_req = 1'b0; sel = 1'b0;
   endtask

   task automatic chk_sig(input int kind, input logic [31:0] exp, input string name);
      @(posedge clk); #1;
      push(kind, exp, name);
      chk_req = 1'b1;
      @(posedge clk); #1;
      chk_req = 1'b0;
   endtask

   // which: 0 vblank, 1 hblank
   task automatic pulse(input int which);
      @(posedge clk); #1;
      if (which == 0) vblank = 1'b1; else hblank = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vblank = 1'b0; hblank = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   // Raise vblank so its rise registers on the same edge that captures the write.
   task automatic rise_with_write(input int w, input logic [3:0] be, input logic [31:0] d);
      @(posedge clk); #1;
      vblank = 1'b1;
      repeat (SYNC_STAGES) @(posedge clk);
      #1;
      sel = 1'b1; addr = 32'(w << 2); we = be; wdata = d;
      @(posedge clk); #1;
      sel = 1'b0; we = '0; vblank = 1'b0;
      repeat (5) @(posedge clk);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Reset state
      for (int i = 0; i < 4 + int'(NUM_SCROLL); i++) chk_rd(i, 32'h0, "reset_read");
      chk_sig(1, 32'h0, "reset_irq");
      chk_sig(2, 32'h0, "reset_vga_en");
      chk_sig(3, 32'h0, "reset_scroll");

      // CTRL with byte enables
      wr(0, 4'b0001, 32'h7);
      chk_sig(2, 32'h1, "ctrl_vga_en");
      chk_rd(0, 32'h7, "ctrl_read");
      wr(0, 4'b0010, 32'hFF);
      chk_rd(0, 32'h7, "ctrl_wrong_byte");
      chk_sig(0, 32'h0, "rdata_unselected");
      chk_rd(12, 32'h0, "rdata_unmapped");

      // Interrupts: hblank enable only
      wr(0, 4'b0001, 32'h5);
      pulse(0);
      chk_rd(2, 32'h1, "int_vblank");
      chk_sig(1, 32'h0, "irq_masked");
      pulse(1);
      chk_rd(2, 32'h3, "int_both");
      chk_sig(1, 32'h1, "irq_hblank");
      wr(2, 4'b0001, 32'h2);
      chk_rd(2, 32'h1, "int_w1c");
      chk_sig(1, 32'h0, "irq_cleared");

      // Set wins over coincident W1C
      wr(2, 4'b0001, 32'h1);
      chk_rd(2, 32'h0, "int_cleared");
      rise_with_write(2, 4'b0001, 32'h1);
      chk_rd(2, 32'h1, "int_set_wins");

      // Scroll double buffering
      wr(4, 4'b0011, 32'h1234);
      chk_sig(3, 32'h0, "scroll_held");
      chk_rd(4, 32'h1234, "scroll0_pending");
      pulse(0);
      chk_sig(3, 32'h0000_1234, "scroll_transfer");
      chk_rd(4, 32'h1234, "scroll0_after");
      rise_with_write(5, 4'b0011, 32'hABCD);
      chk_sig(3, 32'hABCD_1234, "scroll_same_cycle");
      chk_rd(5, 32'hABCD, "scroll1_pending");
      wr(4, 4'b0010, 32'h5600);
      chk_rd(4, 32'h5634, "scroll0_byte1");
      chk_sig(3, 32'hABCD_1234, "scroll_no_early");

      // Frame counter
`ifdef REG_VGA_FRAME_CNT_EN
      wr(3, 4'b1000, 32'h0);
      chk_rd(3, 32'h0, "frame_clear");
      repeat (3) pulse(0);
      chk_rd(3, 32'h3, "frame_three");
      rise_with_write(3, 4'b0100, 32'h0);
      chk_rd(3, 32'h1, "frame_clear_rise");
      wr(3, 4'b0001, 32'h0);
      repeat (15) pulse(0);
      chk_rd(3, 32'hF, "frame_max");
      pulse(0);
      chk_rd(3, 32'h0, "frame_wrap");
`else
      repeat (2) pulse(0);
      chk_rd(3, 32'h0, "frame_absent");
      wr(3, 4'b0001, 32'h5);
      chk_rd(3, 32'h0, "frame_absent_wr");
`endif

      // Reset while vblank is high
      wr(2, 4'b0001, 32'h3);
      @(posedge clk); #1 vblank = 1'b1;
      repeat (5) @(posedge clk);
      chk_rd(2, 32'h1, "int_pre_reset");
      chk_rd(1, 32'h1, "status_vblank");
      #1 rst_n = 1'b0;
      chk_sig(2, 32'h0, "rst_vga_en");
      chk_sig(3, 32'h0, "rst_scroll");
      chk_rd(2, 32'h0, "rst_int_stat");
      #1 rst_n = 1'b1;
      repeat (6) @(posedge clk);
      chk_rd(1, 32'h1, "status_after_rst");
      chk_rd(2, 32'h0, "no_edge_after_rst");
      #1 vblank = 1'b0;
      repeat (4) @(posedge clk);
      pulse(0);
      chk_rd(2, 32'h1, "edge_after_rst");

      @(posedge clk); #1 done_req = 1'b1;
      @(posedge clk); #1 done_req = 1'b0;
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
